control_unit: RTL

- Hardwired fetch/decode/execute sequencer that drives every control input of the datapath `system` (ARF, register file, IR, ALU, memory, muxes A/B/C).
- Consumes IR contents and ALU flags.
- Sits beside `system` at the top level: `system` responds to control words, and this block issues them.

---
 rtl/control_unit_pkg.sv | 90 +++++++++
 rtl/control_unit_if.sv | 40 ++++
 rtl/control_unit_regsel_dec.sv | 11 +
 rtl/control_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired control unit: state codes, opcodes,
// datapath function/select codes and the idle control word.
package control_unit_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH_L = 3'd1,
        ST_FETCH_H = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM     = 3'd4,
        ST_HALT    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        OP_AND  = 4'h0, OP_OR   = 4'h1, OP_NOT  = 4'h2, OP_ADD  = 4'h3,
        OP_SUB  = 4'h4, OP_LSR  = 4'h5, OP_LSL  = 4'h6, OP_LD   = 4'h7,
        OP_ST   = 4'h8, OP_MOVI = 4'h9, OP_BRA  = 4'hA, OP_BEQ  = 4'hB,
        OP_BNE  = 4'hC, OP_INC  = 4'hD, OP_DEC  = 4'hE, OP_HLT  = 4'hF
    } opcode_t;

    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_NOT  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_LSL  = 4'b1011;
    localparam logic [3:0] ALU_LSR  = 4'b1100;

    localparam logic [1:0] FUN_CLR  = 2'b00;
    localparam logic [1:0] FUN_LOAD = 2'b01;
    localparam logic [1:0] FUN_DEC  = 2'b10;
    localparam logic [1:0] FUN_INC  = 2'b11;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_MEM  = 2'b01;
    localparam logic [1:0] MUX_IMM  = 2'b10;

    localparam logic [1:0] ARF_SEL_AR = 2'd0;
    localparam logic [1:0] ARF_SEL_PC = 2'd3;
    localparam logic [3:0] ARF_EN_AR  = 4'b1000;
    localparam logic [3:0] ARF_EN_PC  = 4'b0001;
    localparam logic [3:0] EN_ALL     = 4'b1111;

    typedef struct packed {
        logic [1:0] outasel;
        logic [1:0] outbsel;
        logic [1:0] funsel_ir;
        logic [1:0] funsel_arf;
        logic [1:0] funsel_rf;
        logic [3:0] funsel_alu;
        logic [3:0] regsel_rf;
        logic [3:0] rf_tsel;
        logic [3:0] regsel_arf;
        logic       wr_mem;
        logic       cs_mem;
        logic       ir_enable;
        logic       ir_lh;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
    } ctrl_word_t;

    // Memory chip select is active low, so the idle word keeps it high.
    localparam ctrl_word_t IDLE_WORD = '{cs_mem: 1'b1, default: '0};

    function automatic logic [2:0] rf_sel(input logic [1:0] n);
        return 3'd4 + {1'b0, n};
    endfunction

    function automatic logic is_alu_op(input opcode_t op);
        return op <= OP_LSL;
    endfunction

    function automatic logic [3:0] alu_code(input opcode_t op);
        case (op)
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_NOT:  return ALU_NOT;
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_LSR:  return ALU_LSR;
            OP_LSL:  return ALU_LSL;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the control unit (master) and the datapath (slave).
// No valid/ready: the word is combinational and the datapath takes it every rising clk.
interface control_unit_if;
    logic [15:0] ir_out;
    logic [3:0]  alu_flag;
    logic [1:0]  outasel;
    logic [1:0]  outbsel;
    logic [1:0]  funsel_IR;
    logic [1:0]  funsel_arf;
    logic [1:0]  funsel_rf;
    logic [3:0]  funsel_alu;
    logic [3:0]  regsel_rf;
    logic [3:0]  rf_tsel;
    logic [3:0]  regsel_arf;
    logic        wrMEM;
    logic        csMEM;
    logic        IR_enable;
    logic        IR_lh;
    logic [1:0]  MUXSelA;
    logic [1:0]  MUXSelB;
    logic        MUXSelC;
    logic [2:0]  rf_o1sel;
    logic [2:0]  rf_o2sel;
    logic        halted;
    logic [2:0]  sc;

    modport master (
        input  ir_out, alu_flag,
        output outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu,
               regsel_rf, rf_tsel, regsel_arf, wrMEM, csMEM, IR_enable, IR_lh,
               MUXSelA, MUXSelB, MUXSelC, rf_o1sel, rf_o2sel, halted, sc
    );

    modport slave (
        output ir_out, alu_flag,
        input  outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu,
               regsel_rf, rf_tsel, regsel_arf, wrMEM, csMEM, IR_enable, IR_lh,
               MUXSelA, MUXSelB, MUXSelC, rf_o1sel, rf_o2sel, halted, sc
    );
endinterface

// File: rtl/control_unit_regsel_dec.sv
// Register index decoder: 2-bit index to one-hot enable (bit 3-n) and RF output select (4+n).
module regsel_dec
    import control_unit_pkg::*;
(
    input  logic [1:0] idx,
    output logic [3:0] onehot,
    output logic [2:0] sel
);
    assign onehot = 4'b1000 >> idx;
    assign sel    = rf_sel(idx);
endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving every control input of the datapath.
// Three-process FSM; the state code is exported on sc for debug.
module control_unit
    import control_unit_pkg::*;
#(
    parameter bit RST_CLEAR = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    control_unit_if.master bus
);

    state_t     state;
    state_t     next_state;
    logic       z_q;
    ctrl_word_t cw;
    opcode_t    op;
    logic [1:0] dst;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [3:0] dst_en;
    logic [2:0] dst_sel;
    logic       unused_bits;

    assign op  = opcode_t'(bus.ir_out[15:12]);
    assign dst = bus.ir_out[9:8];
    assign s1  = bus.ir_out[5:4];
    assign s2  = bus.ir_out[1:0];
    // The immediate is routed by the datapath itself; only Z matters for branching.
    assign unused_bits = ^{bus.ir_out[11:10], bus.ir_out[7:6], bus.ir_out[3:2],
                           bus.alu_flag[2:0]};

    regsel_dec u_dst_dec (
        .idx    (dst),
        .onehot (dst_en),
        .sel    (dst_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_CLEAR ? ST_INIT : ST_FETCH_L;
        end else begin
            state <= next_state;
        end
    end

    // Branches test the Z captured by the last ALU instruction, not the live flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
        end else if (state == ST_EXEC && is_alu_op(op)) begin
            z_q <= bus.alu_flag[3];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:    next_state = ST_FETCH_L;
            ST_FETCH_L: next_state = ST_FETCH_H;
            ST_FETCH_H: next_state = ST_EXEC;
            ST_EXEC: begin
                if (op == OP_LD || op == OP_ST) begin
                    next_state = ST_MEM;
                end else if (op == OP_HLT) begin
                    next_state = ST_HALT;
                end else begin
                    next_state = ST_FETCH_L;
                end
            end
            ST_MEM:     next_state = ST_FETCH_L;
            ST_HALT:    next_state = ST_HALT;
            default:    next_state = ST_FETCH_L;
        endcase
    end

    always_comb begin
        cw = IDLE_WORD;
        case (state)
            ST_INIT: begin
                cw.regsel_arf = EN_ALL;
                cw.regsel_rf  = EN_ALL;
                cw.rf_tsel    = EN_ALL;
                cw.funsel_arf = FUN_CLR;
                cw.funsel_rf  = FUN_CLR;
            end
            ST_FETCH_L, ST_FETCH_H: begin
                cw.outbsel    = ARF_SEL_PC;
                cw.cs_mem     = 1'b0;
                cw.ir_enable  = 1'b1;
                cw.funsel_ir  = FUN_LOAD;
                cw.ir_lh      = (state == ST_FETCH_H);
                cw.regsel_arf = ARF_EN_PC;
                cw.funsel_arf = FUN_INC;
            end
            ST_EXEC: begin
                case (op)
                    OP_AND, OP_OR, OP_NOT, OP_ADD, OP_SUB, OP_LSR, OP_LSL: begin
                        cw.rf_o1sel   = rf_sel(s1);
                        cw.rf_o2sel   = rf_sel(s2);
                        cw.mux_c      = 1'b0;
                        cw.funsel_alu = alu_code(op);
                        cw.mux_a      = MUX_ALU;
                        cw.funsel_rf  = FUN_LOAD;
                        cw.regsel_rf  = dst_en;
                    end
                    OP_LD, OP_ST: begin
                        cw.mux_b      = MUX_IMM;
                        cw.funsel_arf = FUN_LOAD;
                        cw.regsel_arf = ARF_EN_AR;
                    end
                    OP_MOVI: begin
                        cw.mux_a     = MUX_IMM;
                        cw.funsel_rf = FUN_LOAD;
                        cw.regsel_rf = dst_en;
                    end
                    OP_BRA, OP_BEQ, OP_BNE: begin
                        if (op == OP_BRA || (op == OP_BEQ && z_q) || (op == OP_BNE && !z_q)) begin
                            cw.mux_b      = MUX_IMM;
                            cw.funsel_arf = FUN_LOAD;
                            cw.regsel_arf = ARF_EN_PC;
                        end
                    end
                    OP_INC: begin
                        cw.funsel_rf = FUN_INC;
                        cw.regsel_rf = dst_en;
                    end
                    OP_DEC: begin
                        cw.funsel_rf = FUN_DEC;
                        cw.regsel_rf = dst_en;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                cw.outbsel = ARF_SEL_AR;
                cw.cs_mem  = 1'b0;
                if (op == OP_ST) begin
                    cw.wr_mem     = 1'b1;
                    cw.rf_o1sel   = dst_sel;
                    cw.mux_c      = 1'b0;
                    cw.funsel_alu = ALU_PASS;
                end else begin
                    cw.wr_mem    = 1'b0;
                    cw.mux_a     = MUX_MEM;
                    cw.funsel_rf = FUN_LOAD;
                    cw.regsel_rf = dst_en;
                end
            end
            default: ;
        endcase
    end

    assign bus.outasel    = cw.outasel;
    assign bus.outbsel    = cw.outbsel;
    assign bus.funsel_IR  = cw.funsel_ir;
    assign bus.funsel_arf = cw.funsel_arf;
    assign bus.funsel_rf  = cw.funsel_rf;
    assign bus.funsel_alu = cw.funsel_alu;
    assign bus.regsel_rf  = cw.regsel_rf;
    assign bus.rf_tsel    = cw.rf_tsel;
    assign bus.regsel_arf = cw.regsel_arf;
    assign bus.wrMEM      = cw.wr_mem;
    assign bus.csMEM      = cw.cs_mem;
    assign bus.IR_enable  = cw.ir_enable;
    assign bus.IR_lh      = cw.ir_lh;
    assign bus.MUXSelA    = cw.mux_a;
    assign bus.MUXSelB    = cw.mux_b;
    assign bus.MUXSelC    = cw.mux_c;
    assign bus.rf_o1sel   = cw.rf_o1sel;
    assign bus.rf_o2sel   = cw.rf_o2sel;
    assign bus.halted     = (state == ST_HALT);
    assign bus.sc         = state;

endmodule
